// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter and sequencer that shares a single shift_add_mult unit
//   between N_REQ requesters. It latches the winning operand pair, pulses
//   M_ST, waits for M_DONE and returns the 2W-bit product to the granted
//   requester. If M_DONE never arrives, the multiplier is recovered with a
//   one-cycle M_RST pulse and an error response is returned.
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   REQ[N_REQ]        per-requester request level
//   REQ_PLIER/CAND    packed operands, requester i at [i*W +: W]
//   GNT[N_REQ]        one-hot pulse: operands captured
//   RSP_VALID[N_REQ]  one-hot pulse: result available
//   RSP_PRODUCT[2W]   result, held until the next response
//   RSP_ERR           error flag qualifying RSP_VALID (timeout)
//   BUSY              high whenever not IDLE
//   M_ST, M_RST       multiplier start pulse / active-high reset
//   M_PLIER, M_CAND   latched operands driven to the multiplier
//   M_DONE, M_PRODUCT multiplier completion and result
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 80
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] REQ_PLIER,
  input  logic [N_REQ*W-1:0] REQ_CAND,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   RSP_VALID,
  output logic [2*W-1:0]     RSP_PRODUCT,
  output logic               RSP_ERR,
  output logic               BUSY,
  output logic               M_ST,
  output logic               M_RST,
  output logic [W-1:0]       M_PLIER,
  output logic [W-1:0]       M_CAND,
  input  logic               M_DONE,
  input  logic [2*W-1:0]     M_PRODUCT
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [TW-1:0]   timer;
  logic            m_rst_pulse;

  logic [PW-1:0]   pick;
  logic [W-1:0]    sel_plier;
  logic [W-1:0]    sel_cand;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] o;
    o = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (idx == PW'(N_REQ - 1)) return '0;
    return idx + PW'(1);
  endfunction

  // Scan from the farthest offset down to offset 0 so the last hit, i.e. the
  // first requester at or after ptr (wrapping), is the one that sticks.
  always_comb begin
    pick = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (REQ[(int'(ptr) + off) % N_REQ]) pick = PW'((int'(ptr) + off) % N_REQ);
    end
  end

  always_comb begin
    sel_plier = REQ_PLIER[int'(pick)*W +: W];
    sel_cand  = REQ_CAND[int'(pick)*W +: W];
  end

  // The multiplier is held in reset for as long as the arbiter is, plus the
  // one-cycle recovery pulse after a timeout.
  assign M_RST = ~RST | m_rst_pulse;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      ptr         <= '0;
      winner      <= '0;
      timer       <= '0;
      m_rst_pulse <= 1'b0;
      GNT         <= '0;
      RSP_VALID   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_PRODUCT <= '0;
      BUSY        <= 1'b0;
      M_ST        <= 1'b0;
      M_PLIER     <= '0;
      M_CAND      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            winner  <= pick;
            M_PLIER <= sel_plier;
            M_CAND  <= sel_cand;
            GNT     <= onehot(pick);
            M_ST    <= 1'b1;
            BUSY    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          GNT   <= '0;
          M_ST  <= 1'b0;
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // timer==0 blanks a DONE left over from the previous operation;
          // DONE takes priority over a coincident timeout.
          if (M_DONE && (timer != '0)) begin
            RSP_PRODUCT <= M_PRODUCT;
            RSP_ERR     <= 1'b0;
            RSP_VALID   <= onehot(winner);
            state       <= S_RESP;
          end else if (timer == TW'(TIMEOUT)) begin
            RSP_PRODUCT <= '0;
            RSP_ERR     <= 1'b1;
            RSP_VALID   <= onehot(winner);
            m_rst_pulse <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          RSP_VALID   <= '0;
          RSP_ERR     <= 1'b0;
          m_rst_pulse <= 1'b0;
          ptr         <= next_ptr(winner);
          BUSY        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] REQ_PLIER;
  logic [N*W-1:0] REQ_CAND;
  logic [N-1:0]   GNT;
  logic [N-1:0]   RSP_VALID;
  logic [2*W-1:0] RSP_PRODUCT;
  logic           RSP_ERR;
  logic           BUSY;
  logic           M_ST;
  logic           M_RST;
  logic [W-1:0]   M_PLIER;
  logic [W-1:0]   M_CAND;
  logic           M_DONE;
  logic [2*W-1:0] M_PRODUCT;

  always #5 CLK = ~CLK;

  mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(80)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_PLIER(REQ_PLIER), .REQ_CAND(REQ_CAND),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_PRODUCT(RSP_PRODUCT), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .M_ST(M_ST), .M_RST(M_RST), .M_PLIER(M_PLIER), .M_CAND(M_CAND),
    .M_DONE(M_DONE), .M_PRODUCT(M_PRODUCT)
  );

  // Multiplier stub: DONE pulses stub_delay cycles after M_ST, or the bench
  // drives DONE/PRODUCT by hand when stub_auto is clear.
  bit             stub_auto = 1'b1;
  int             stub_delay = 33;
  int             stub_cnt = 0;
  logic           stub_done = 1'b0;
  logic [2*W-1:0] stub_prod = '0;
  logic           man_done = 1'b0;
  logic [2*W-1:0] man_prod = '0;

  assign M_DONE    = stub_auto ? stub_done : man_done;
  assign M_PRODUCT = stub_auto ? stub_prod : man_prod;

  always @(negedge CLK) begin
    stub_done = 1'b0;
    if (M_ST) begin
      stub_cnt = stub_delay;
    end else if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_done = 1'b1;
        stub_prod = {32'b0, M_PLIER} * {32'b0, M_CAND};
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_op(input int i, input logic [31:0] p, input logic [31:0] c);
    REQ_PLIER[i*W +: W] = p;
    REQ_CAND[i*W +: W]  = c;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (GNT == '0 && n < 20);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (RSP_VALID == '0 && n < 200);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
  endtask

  logic [63:0] fair_prod [4] = '{64'h110, 64'h220, 64'h330, 64'h440};

  initial begin
    int n;
    int cnt;
    int early;
    RST = 1'b0;
    REQ = '0;
    REQ_PLIER = '0;
    REQ_CAND = '0;
    tick();
    tick();
    check_eq("rst_gnt", GNT, 0);
    check_eq("rst_valid", RSP_VALID, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_mst", M_ST, 0);
    check_eq("rst_mrst", M_RST, 1);
    check_eq("rst_prod", RSP_PRODUCT, 0);
    check_eq("rst_plier", M_PLIER, 0);
    check_eq("rst_ptr", dut.ptr, 0);
    RST = 1'b1;
    tick();
    check_eq("rel_mrst", M_RST, 0);

    // single request
    stub_delay = 33;
    set_op(0, 32'hE94EA3FF, 32'h2);
    REQ = 4'b0001;
    wait_gnt(n);
    check_eq("t1_gnt_lat", 64'(n), 1);
    check_eq("t1_gnt", GNT, 4'b0001);
    check_eq("t1_mst", M_ST, 1);
    check_eq("t1_busy", BUSY, 1);
    check_eq("t1_plier", M_PLIER, 32'hE94EA3FF);
    REQ = '0;
    wait_rsp(n);
    check_eq("t1_rsp_lat", 64'(n), 34);
    check_eq("t1_valid", RSP_VALID, 4'b0001);
    check_eq("t1_prod", RSP_PRODUCT, 64'h00000001D29D47FE);
    check_eq("t1_err", RSP_ERR, 0);
    tick();
    check_eq("t1_valid_pulse", RSP_VALID, 0);
    check_eq("t1_idle_busy", BUSY, 0);
    check_eq("t1_prod_hold", RSP_PRODUCT, 64'h00000001D29D47FE);

    // fairness from a fresh pointer
    do_reset();
    stub_delay = 5;
    for (int i = 0; i < 4; i++) set_op(i, 32'h11 * (i + 1), 32'h10);
    REQ = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(n);
      check_eq("fair_gnt_lat", 64'(n), 1);
      check_eq($sformatf("fair_gnt%0d", k), GNT, 4'b0001 << (k % 4));
      REQ[k % 4] = 1'b0;
      wait_rsp(n);
      check_eq("fair_rsp_lat", 64'(n), 6);
      check_eq($sformatf("fair_valid%0d", k), RSP_VALID, 4'b0001 << (k % 4));
      check_eq($sformatf("fair_prod%0d", k), RSP_PRODUCT, fair_prod[k % 4]);
      if (k == 5) REQ = '0;
      tick();
      if (k != 5) REQ[k % 4] = 1'b1;
    end

    // max operands
    set_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    REQ = 4'b1000;
    wait_gnt(n);
    check_eq("max_gnt", GNT, 4'b1000);
    REQ = '0;
    wait_rsp(n);
    check_eq("max_prod", RSP_PRODUCT, 64'hFFFFFFFE00000001);
    check_eq("max_err", RSP_ERR, 0);
    tick();

    // stale DONE held into the first WAIT cycle
    stub_auto = 1'b0;
    man_done = 1'b1;
    man_prod = 64'hDEAD;
    set_op(0, 32'h7, 32'h9);
    REQ = 4'b0001;
    wait_gnt(n);
    check_eq("stale_gnt", GNT, 4'b0001);
    REQ = '0;
    tick();
    tick();
    man_done = 1'b0;
    early = (RSP_VALID != '0) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (RSP_VALID != '0) early++;
    end
    tick();
    if (RSP_VALID != '0) early++;
    man_done = 1'b1;
    man_prod = 64'h123456789ABCDEF0;
    tick();
    check_eq("stale_early", 64'(early), 0);
    check_eq("stale_valid", RSP_VALID, 4'b0001);
    check_eq("stale_prod", RSP_PRODUCT, 64'h123456789ABCDEF0);
    check_eq("stale_err", RSP_ERR, 0);
    man_done = 1'b0;
    tick();

    // timeout: DONE never arrives
    set_op(1, 32'h5, 32'h7);
    REQ = 4'b0010;
    wait_gnt(n);
    check_eq("to_gnt", GNT, 4'b0010);
    REQ = '0;
    n = 0;
    cnt = 0;
    do begin
      tick();
      n++;
      if (M_RST) cnt++;
    end while (RSP_VALID == '0 && n < 120);
    check_eq("to_lat", 64'(n), 82);
    check_eq("to_valid", RSP_VALID, 4'b0010);
    check_eq("to_err", RSP_ERR, 1);
    check_eq("to_prod", RSP_PRODUCT, 0);
    tick();
    if (M_RST) cnt++;
    check_eq("to_mrst_pulses", 64'(cnt), 1);
    check_eq("to_err_clear", RSP_ERR, 0);

    // recovery: next request completes normally
    stub_auto = 1'b1;
    stub_delay = 10;
    set_op(2, 32'hFFFF, 32'h10001);
    REQ = 4'b0100;
    wait_gnt(n);
    check_eq("rec_gnt", GNT, 4'b0100);
    REQ = '0;
    wait_rsp(n);
    check_eq("rec_lat", 64'(n), 11);
    check_eq("rec_prod", RSP_PRODUCT, 64'hFFFFFFFF);
    check_eq("rec_err", RSP_ERR, 0);
    tick();

    // DONE coincident with timer==TIMEOUT wins
    stub_auto = 1'b0;
    set_op(3, 32'h3, 32'h3);
    REQ = 4'b1000;
    wait_gnt(n);
    check_eq("tie_gnt", GNT, 4'b1000);
    REQ = '0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (RSP_VALID != '0 || M_RST) cnt++;
    end
    tick();
    man_done = 1'b1;
    man_prod = 64'h9;
    tick();
    check_eq("tie_quiet", 64'(cnt), 0);
    check_eq("tie_valid", RSP_VALID, 4'b1000);
    check_eq("tie_err", RSP_ERR, 0);
    check_eq("tie_prod", RSP_PRODUCT, 64'h9);
    check_eq("tie_mrst", M_RST, 0);
    man_done = 1'b0;
    tick();

    // reset during WAIT
    stub_auto = 1'b1;
    stub_delay = 5;
    set_op(0, 32'h2, 32'h2);
    REQ = 4'b0001;
    wait_gnt(n);
    REQ = '0;
    wait_rsp(n);
    tick();
    stub_delay = 20;
    set_op(1, 32'h4, 32'h4);
    REQ = 4'b0010;
    wait_gnt(n);
    check_eq("mr_gnt", GNT, 4'b0010);
    REQ = '0;
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b0;
    tick();
    check_eq("mr_busy", BUSY, 0);
    check_eq("mr_mrst", M_RST, 1);
    tick();
    RST = 1'b1;
    check_eq("mr_ptr", dut.ptr, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (RSP_VALID != '0 || BUSY) cnt++;
    end
    check_eq("mr_no_rsp", 64'(cnt), 0);
    set_op(2, 32'h6, 32'h7);
    REQ = 4'b0100;
    wait_gnt(n);
    check_eq("mr_gnt2_lat", 64'(n), 1);
    check_eq("mr_gnt2", GNT, 4'b0100);
    REQ = '0;
    wait_rsp(n);
    check_eq("mr_rsp_lat", 64'(n), 21);
    check_eq("mr_valid", RSP_VALID, 4'b0100);
    check_eq("mr_prod", RSP_PRODUCT, 64'h2A);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
